ps2_host_tx: RTL and testbench
==============================

# ps2_host_tx

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable) from the FPGA to the keyboard using the standard PS/2 host-request protocol. It sits beside the PS/2 receive controller on the same open-drain PS2_CLK/PS2_DAT pair, driving each line only low or Z, so that the keyboard-input path can configure the device. Completion and device acknowledge are reported with a one-cycle done pulse and an error flag.

## Interface

- INHIBIT_CYCLES, 5000: CLOCK_50 cycles PS2_CLK is held low before the request (100 µs at 50 MHz).
- START_TIMEOUT_CYCLES, 750000: maximum wait from request to the device's first clock falling edge (15 ms).
- XFER_TIMEOUT_CYCLES, 100000: maximum time from the first falling edge to return to bus idle (2 ms).
- CLOCK_50  input  1  system clock; the only clock.
- reset  input  1  asynchronous, active-low reset.
- cmd_data  input  8  command byte; sampled on the accept cycle only.
- cmd_send  input  1  request strobe; accepted only when busy=0.
- busy  output  1  high from the cycle after accept until the cycle after cmd_done.
- cmd_done  output  1  one-cycle pulse at the end of every accepted command.
- cmd_error  output  1  valid with cmd_done: 1 = NACK or timeout, 0 = acknowledged.
- PS2_CLK  inout  1  open-drain: driven 0 or Z, never 1.
- PS2_DAT  inout  1  open-drain: driven 0 or Z, never 1.

## Operation

- Each input line passes through a 2-FF synchronizer. A falling edge is synced previous=1 and current=0. Edges are counted only in WAIT_CLK, DATA and ACK.
- Frame: start 0, data bits 0–7 LSB first, odd parity (1 when data has an even number of ones), stop (DAT released), then the device ack.
- States and transitions:
  - IDLE: both lines Z. When cmd_send=1, latch cmd_data, compute parity, go to INHIBIT.
  - INHIBIT: CLK=0, DAT=Z for INHIBIT_CYCLES cycles, then go to REQ.
  - REQ: CLK=0, DAT=0 for 1 cycle, then go to WAIT_CLK. Clear the timer.
  - WAIT_CLK: CLK=Z, DAT=0.
    - Falling edge 1: drive data bit 0, bit count=1, clear the timer, go to DATA.
    - Timer reaches START_TIMEOUT_CYCLES: go to FAIL.
  - DATA: falling edges 2–8 drive data bits 1–7. Edge 9 drives parity. Edge 10 releases DAT (stop), then go to ACK.
  - ACK: on falling edge 11, sample synced DAT. 0 = ACK, 1 = NACK (recorded). Go to WAIT_IDLE.
  - WAIT_IDLE: wait until synced CLK=1 and DAT=1, then pulse cmd_done with cmd_error = recorded NACK. Go to IDLE.
  - FAIL: release both lines, pulse cmd_done with cmd_error=1, go to IDLE.
- In DATA, ACK and WAIT_IDLE, the timer reaching XFER_TIMEOUT_CYCLES forces FAIL.
- Driving 0 on DAT sets the output enable; a data or parity bit of 1 is Z.
- cmd_send is ignored while busy. A cmd_send held high is re-accepted only in IDLE, i.e. the cycle after cmd_done.
- Counters: the bit count is 4 bits. The timer is sized by $clog2 of the largest parameter and saturates, with no wrap.

## Timing

- Reset values: PS2_CLK=Z, PS2_DAT=Z, busy=0, cmd_done=0, cmd_error=0, state IDLE.
- Reset asserted at any point, including mid-frame, releases both lines immediately (asynchronously) and abandons the frame. No cmd_done is produced.
- Accept at edge T: from T+1, busy=1 and CLK=0. CLK is low for INHIBIT_CYCLES+1 cycles, with DAT=0 in the final cycle, then released.
- The DAT update follows a PS2_CLK fall within 3 CLOCK_50 cycles (2 sync + 1 register), well inside the device's low half-period (≥30 µs).
- cmd_done is high for exactly 1 cycle. cmd_error is valid in that cycle and held until the next accept. busy falls in the cycle after cmd_done.
- The cmd_done-to-next-accept minimum is 1 cycle.

## Test plan

- Send 0xED with a device model at 12.5 kHz that acks.
  - Device samples 0, 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - CLK is low 5001 cycles before release.
  - cmd_done=1 with cmd_error=0, and the bus ends idle.
- Send 0x01 and 0x00.
  - Parity is 0 and 1 respectively.
  - Data and parity bits are never driven high (check the OE only).
- Device returns DAT=1 at edge 11 (NACK): cmd_done with cmd_error=1.
- No device clocking after the request: cmd_done and cmd_error pulse START_TIMEOUT_CYCLES+1 (±2) cycles after CLK release, and both lines are Z.
- Device stops after 5 falling edges: cmd_error=1 at XFER_TIMEOUT_CYCLES (±3 cycles) after edge 1.
- Mid-frame cases:
  - cmd_send=1 with 0x55 at edge 4 of a 0xF4 frame: ignored, and 0xF4 completes intact.
  - reset low at edge 6: both lines are Z within the reset assertion, busy=0, and no cmd_done.

Source files
------------

// File: rtl/ps2_host_tx.sv
// ps2_host_tx
// Host-to-device PS/2 transmitter. Sends one command byte to the keyboard
// using the PS/2 host-request sequence: inhibit, request, then eleven clocks
// from the device. The device supplies those clocks as start, 8 data bits
// (LSB first), odd parity, stop, and ack. Both bus lines are open-drain.
// This block only ever pulls a line low or releases it.
//
// Ports
//   CLOCK_50  : system clock, the only clock
//   reset     : asynchronous, active-low reset
//   cmd_data  : command byte, sampled on the accept cycle
//   cmd_send  : request strobe, accepted only while busy is low
//   busy      : high from the cycle after accept until the cycle after cmd_done
//   cmd_done  : one-cycle pulse when an accepted command finishes
//   cmd_error : valid with cmd_done (1 = NACK or timeout); held until next accept
//   PS2_CLK   : open-drain PS/2 clock (driven 0 or Z)
//   PS2_DAT   : open-drain PS/2 data  (driven 0 or Z)
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES       = 5000,
  parameter int START_TIMEOUT_CYCLES = 750000,
  parameter int XFER_TIMEOUT_CYCLES  = 100000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] cmd_data,
  input  logic       cmd_send,
  output logic       busy,
  output logic       cmd_done,
  output logic       cmd_error,
  inout  wire        PS2_CLK,
  inout  wire        PS2_DAT
);

  localparam int MAX_AB  = (INHIBIT_CYCLES > START_TIMEOUT_CYCLES) ?
                           INHIBIT_CYCLES : START_TIMEOUT_CYCLES;
  localparam int MAX_CYC = (MAX_AB > XFER_TIMEOUT_CYCLES) ? MAX_AB : XFER_TIMEOUT_CYCLES;
  localparam int TW      = $clog2(MAX_CYC + 1);

  localparam logic [TW-1:0] INHIBIT_LAST = TW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] START_LIM    = TW'(START_TIMEOUT_CYCLES);
  // The transfer timer starts about two cycles after the physical first
  // falling edge, because the edge must pass through the synchronizer. The
  // limit is pulled in by that lag so the abort lands on the intended
  // distance from the edge on the wire.
  localparam logic [TW-1:0] XFER_ABORT   = TW'(XFER_TIMEOUT_CYCLES - 2);
  localparam logic [TW-1:0] TIMER_MAX    = {TW{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_WAIT_CLK, S_DATA, S_ACK, S_WAIT_IDLE, S_FAIL
  } state_t;

  state_t        r_state,   w_state_nxt;
  logic [1:0]    r_clk_sync, r_dat_sync;
  logic          r_clk_prev;
  logic [7:0]    r_data,    w_data_nxt;
  logic          r_parity,  w_parity_nxt;
  logic [3:0]    r_bit_cnt, w_bit_cnt_nxt;
  logic [TW-1:0] r_timer,   w_timer_nxt;
  logic          r_dat_low, w_dat_low_nxt;
  logic          r_error,   w_error_nxt;
  logic          w_done;
  logic          w_clk_fall;
  logic          w_clk_low;
  logic          w_xfer_to;

  assign w_clk_fall = r_clk_prev & ~r_clk_sync[1];
  assign w_xfer_to  = (r_timer >= XFER_ABORT);

  // State, synchronizers and datapath registers. Reset drops every line
  // enable at once, so the bus is released asynchronously.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_clk_sync <= 2'b11;
      r_dat_sync <= 2'b11;
      r_clk_prev <= 1'b1;
      r_data     <= 8'h00;
      r_parity   <= 1'b0;
      r_bit_cnt  <= 4'd0;
      r_timer    <= '0;
      r_dat_low  <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_clk_sync <= {r_clk_sync[0], PS2_CLK};
      r_dat_sync <= {r_dat_sync[0], PS2_DAT};
      r_clk_prev <= r_clk_sync[1];
      r_data     <= w_data_nxt;
      r_parity   <= w_parity_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_timer    <= w_timer_nxt;
      r_dat_low  <= w_dat_low_nxt;
      r_error    <= w_error_nxt;
    end
  end

  // Next-state logic. The timer free-runs and saturates by default. Each
  // state clears it where a new interval starts. Any route into FAIL
  // releases DAT and records the error, so cmd_error is valid during FAIL.
  always_comb begin
    w_state_nxt   = r_state;
    w_data_nxt    = r_data;
    w_parity_nxt  = r_parity;
    w_bit_cnt_nxt = r_bit_cnt;
    w_timer_nxt   = (r_timer == TIMER_MAX) ? r_timer : r_timer + 1'b1;
    w_dat_low_nxt = r_dat_low;
    w_error_nxt   = r_error;
    w_done        = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_timer_nxt = '0;
        if (cmd_send) begin
          w_data_nxt    = cmd_data;
          w_parity_nxt  = ~^cmd_data;
          w_bit_cnt_nxt = 4'd0;
          w_dat_low_nxt = 1'b0;
          w_error_nxt   = 1'b0;
          w_state_nxt   = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (r_timer == INHIBIT_LAST) begin
          w_dat_low_nxt = 1'b1;
          w_state_nxt   = S_REQ;
        end
      end
      S_REQ: begin
        w_timer_nxt = '0;
        w_state_nxt = S_WAIT_CLK;
      end
      S_WAIT_CLK: begin
        if (w_clk_fall) begin
          w_dat_low_nxt = ~r_data[0];
          w_bit_cnt_nxt = 4'd1;
          w_timer_nxt   = '0;
          w_state_nxt   = S_DATA;
        end else if (r_timer >= START_LIM) begin
          w_dat_low_nxt = 1'b0;
          w_error_nxt   = 1'b1;
          w_state_nxt   = S_FAIL;
        end
      end
      S_DATA: begin
        if (w_xfer_to) begin
          w_dat_low_nxt = 1'b0;
          w_error_nxt   = 1'b1;
          w_state_nxt   = S_FAIL;
        end else if (w_clk_fall) begin
          if (r_bit_cnt < 4'd8) begin
            w_dat_low_nxt = ~r_data[r_bit_cnt[2:0]];
            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
          end else if (r_bit_cnt == 4'd8) begin
            w_dat_low_nxt = ~r_parity;
            w_bit_cnt_nxt = 4'd9;
          end else begin
            w_dat_low_nxt = 1'b0;
            w_bit_cnt_nxt = 4'd10;
            w_state_nxt   = S_ACK;
          end
        end
      end
      S_ACK: begin
        if (w_xfer_to) begin
          w_error_nxt = 1'b1;
          w_state_nxt = S_FAIL;
        end else if (w_clk_fall) begin
          w_error_nxt   = r_dat_sync[1];
          w_bit_cnt_nxt = 4'd11;
          w_state_nxt   = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (w_xfer_to) begin
          w_error_nxt = 1'b1;
          w_state_nxt = S_FAIL;
        end else if (r_clk_sync[1] && r_dat_sync[1]) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_FAIL: begin
        w_dat_low_nxt = 1'b0;
        w_error_nxt   = 1'b1;
        w_done        = 1'b1;
        w_state_nxt   = S_IDLE;
      end
      default: begin
        w_dat_low_nxt = 1'b0;
        w_state_nxt   = S_IDLE;
      end
    endcase
  end

  assign w_clk_low = (r_state == S_INHIBIT) || (r_state == S_REQ);

  assign PS2_CLK   = w_clk_low ? 1'b0 : 1'bz;
  assign PS2_DAT   = r_dat_low ? 1'b0 : 1'bz;
  assign busy      = (r_state != S_IDLE);
  assign cmd_done  = w_done;
  assign cmd_error = r_error;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a scoreboard. Commands push their
// expected cmd_error into a queue. A monitor pops one entry on every
// cmd_done. A behavioural keyboard drives the open-drain bus and reports the
// frame it received. Timing parameters are shrunk to keep runs short.
module tb_ps2_host_tx;

  localparam int INH  = 40;
  localparam int STO  = 300;
  localparam int XTO  = 1500;
  localparam int HP   = 20;
  localparam int TCLK = 20;

  logic       clock50;
  logic       resetN;
  logic [7:0] cmdData;
  logic       cmdSend;
  logic       busy;
  logic       cmdDone;
  logic       cmdError;
  wire        ps2Clk;
  wire        ps2Dat;
  logic       devClkLow;
  logic       devDatLow;

  pullup (ps2Clk);
  pullup (ps2Dat);
  assign ps2Clk = devClkLow ? 1'b0 : 1'bz;
  assign ps2Dat = devDatLow ? 1'b0 : 1'bz;

  int  nChecks = 0;
  int  nErrors = 0;
  int  doneCount = 0;
  time lastDoneTime = 0;
  time edge1Time = 0;
  logic lastDoneClk, lastDoneDat;
  bit  expErrQ[$];

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .START_TIMEOUT_CYCLES(STO),
    .XFER_TIMEOUT_CYCLES(XTO)
  ) dut (
    .CLOCK_50(clock50),
    .reset(resetN),
    .cmd_data(cmdData),
    .cmd_send(cmdSend),
    .busy(busy),
    .cmd_done(cmdDone),
    .cmd_error(cmdError),
    .PS2_CLK(ps2Clk),
    .PS2_DAT(ps2Dat)
  );

  // 50 MHz system clock.
  initial clock50 = 1'b0;
  always #(TCLK/2) clock50 = ~clock50;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkRange(input string name, input int actual, input int lo, input int hi);
    nChecks++;
    if (actual < lo || actual > hi) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0d, want %0d..%0d", name, actual, lo, hi);
    end
  endtask

  // Scoreboard monitor. Every cmd_done must match a queued expectation.
  // This also catches a done during reset or after an abandoned frame.
  always @(negedge clock50) begin
    if (cmdDone === 1'b1) begin
      doneCount++;
      lastDoneTime = $time;
      lastDoneClk  = ps2Clk;
      lastDoneDat  = ps2Dat;
      if (expErrQ.size() == 0) begin
        checkOutput("unexpectedDone", 32'd1, 32'd0);
      end else begin
        checkOutput("cmdError", {31'd0, cmdError}, {31'd0, expErrQ.pop_front()});
      end
    end
  end

  // Issue one command on the next edge and check busy in the cycle after.
  task automatic applyStimulus(input logic [7:0] cmd, input bit expectDone, input bit expErr);
    @(negedge clock50);
    cmdData = cmd;
    cmdSend = 1'b1;
    if (expectDone) expErrQ.push_back(expErr);
    @(negedge clock50);
    cmdSend = 1'b0;
    checkOutput("busyAfterAccept", {31'd0, busy}, 32'd1);
  endtask

  // Wait, with a bounded budget, until the scoreboard has drained.
  task automatic drainScoreboard();
    int n = 0;
    while (expErrQ.size() != 0 && n < 4000) begin
      @(negedge clock50);
      n++;
    end
    if (expErrQ.size() != 0) begin
      checkOutput("drainTimeout", expErrQ.size(), 32'd0);
      expErrQ.delete();
    end
  endtask

  // Keyboard model. It waits for the request (CLK released, DAT low) and
  // then clocks nEdges falling edges, sampling DAT at the end of each low
  // phase. Optional hooks strobe cmd_send mid-frame or pulse reset.
  task automatic deviceFrame(input logic [7:0] expByte, input bit expPar, input int nEdges,
                             input bit ackLow, input int injectEdge, input int resetEdge);
    int   w = 0;
    logic startBit, rxPar, rxStop, s;
    logic [7:0] rxByte = 8'h00;
    rxPar = 1'b0;
    rxStop = 1'b0;
    while (!(ps2Clk === 1'b1 && ps2Dat === 1'b0) && w < 500) begin
      @(negedge clock50);
      w++;
    end
    if (w >= 500) begin
      checkOutput("requestTimeout", 32'd1, 32'd0);
      return;
    end
    startBit = ps2Dat;
    repeat (5) @(negedge clock50);
    for (int i = 1; i <= nEdges; i++) begin
      if (i == 11) begin
        devDatLow = ackLow;
        repeat (HP/2) @(negedge clock50);
      end
      devClkLow = 1'b1;
      if (i == 1) edge1Time = $time;
      if (i == injectEdge) begin
        repeat (2) @(negedge clock50);
        cmdData = 8'h55;
        cmdSend = 1'b1;
        repeat (3) @(negedge clock50);
        cmdSend = 1'b0;
        cmdData = 8'h00;
        repeat (HP-5) @(negedge clock50);
      end else begin
        repeat (HP) @(negedge clock50);
      end
      s = ps2Dat;
      if (i <= 8) rxByte[i-1] = s;
      else if (i == 9) rxPar = s;
      else if (i == 10) rxStop = s;
      devClkLow = 1'b0;
      if (i == resetEdge) begin
        repeat (3) @(negedge clock50);
        resetN = 1'b0;
        #1;
        checkOutput("resetClkZ", {31'd0, ps2Clk}, 32'd1);
        checkOutput("resetDatZ", {31'd0, ps2Dat}, 32'd1);
        checkOutput("resetBusy", {31'd0, busy}, 32'd0);
        checkOutput("resetDone", {31'd0, cmdDone}, 32'd0);
        repeat (3) @(negedge clock50);
        resetN = 1'b1;
        return;
      end
      repeat (HP) @(negedge clock50);
    end
    devDatLow = 1'b0;
    if (nEdges == 11) begin
      checkOutput("startBit", {31'd0, startBit}, 32'd0);
      checkOutput("dataByte", {24'd0, rxByte}, {24'd0, expByte});
      checkOutput("parityBit", {31'd0, rxPar}, {31'd0, expPar});
      checkOutput("stopBit", {31'd0, rxStop}, 32'd1);
    end
  endtask

  // Main directed sequence. Parities are hand-computed: ED->1, 01->0,
  // 00->1, FF->1, F4->0.
  initial begin
    int   cnt, n, doneBefore;
    logic datBefore, datLast;
    time  t0;
    resetN = 1'b0;
    cmdSend = 1'b0;
    cmdData = 8'h00;
    devClkLow = 1'b0;
    devDatLow = 1'b0;
    repeat (5) @(negedge clock50);
    checkOutput("resetBusy0", {31'd0, busy}, 32'd0);
    checkOutput("resetDone0", {31'd0, cmdDone}, 32'd0);
    checkOutput("resetErr0", {31'd0, cmdError}, 32'd0);
    checkOutput("resetClk0", {31'd0, ps2Clk}, 32'd1);
    checkOutput("resetDat0", {31'd0, ps2Dat}, 32'd1);
    resetN = 1'b1;
    repeat (3) @(negedge clock50);

    // 0xED with ack; CLK must stay low INH+1 cycles, DAT low only in the last.
    applyStimulus(8'hED, 1'b1, 1'b0);
    cnt = 0;
    datBefore = 1'bx;
    datLast = 1'bx;
    while (ps2Clk === 1'b0 && cnt < 200) begin
      cnt++;
      if (cnt == INH) datBefore = ps2Dat;
      datLast = ps2Dat;
      @(negedge clock50);
    end
    checkOutput("inhibitCycles", cnt, INH + 1);
    checkOutput("inhibitDatReleased", {31'd0, datBefore}, 32'd1);
    checkOutput("requestDatLow", {31'd0, datLast}, 32'd0);
    deviceFrame(8'hED, 1'b1, 11, 1'b1, 0, 0);
    drainScoreboard();
    @(negedge clock50);
    checkOutput("busyAfterDone", {31'd0, busy}, 32'd0);
    checkOutput("idleClk", {31'd0, ps2Clk}, 32'd1);
    checkOutput("idleDat", {31'd0, ps2Dat}, 32'd1);

    // Parity boundary bytes.
    applyStimulus(8'h01, 1'b1, 1'b0);
    deviceFrame(8'h01, 1'b0, 11, 1'b1, 0, 0);
    drainScoreboard();
    applyStimulus(8'h00, 1'b1, 1'b0);
    deviceFrame(8'h00, 1'b1, 11, 1'b1, 0, 0);
    drainScoreboard();

    // NACK: the device leaves DAT high at edge 11. The error must hold afterwards.
    applyStimulus(8'hFF, 1'b1, 1'b1);
    deviceFrame(8'hFF, 1'b1, 11, 1'b0, 0, 0);
    drainScoreboard();
    repeat (5) @(negedge clock50);
    checkOutput("errorHeld", {31'd0, cmdError}, 32'd1);

    // No device clocking: start timeout measured from CLK release.
    applyStimulus(8'hF4, 1'b1, 1'b1);
    n = 0;
    while (ps2Clk !== 1'b1 && n < 200) begin
      @(negedge clock50);
      n++;
    end
    t0 = $time;
    drainScoreboard();
    checkRange("startTimeout", int'((lastDoneTime - t0) / TCLK), STO - 1, STO + 3);
    checkOutput("startToClkZ", {31'd0, lastDoneClk}, 32'd1);
    checkOutput("startToDatZ", {31'd0, lastDoneDat}, 32'd1);
    repeat (3) @(negedge clock50);

    // Device stops after 5 edges: transfer timeout measured from edge 1.
    applyStimulus(8'hF4, 1'b1, 1'b1);
    deviceFrame(8'hF4, 1'b0, 5, 1'b1, 0, 0);
    drainScoreboard();
    checkRange("xferTimeout", int'((lastDoneTime - edge1Time) / TCLK), XTO - 3, XTO + 3);
    repeat (3) @(negedge clock50);

    // cmd_send 0x55 mid-frame must be ignored; 0xF4 must complete intact.
    doneBefore = doneCount;
    applyStimulus(8'hF4, 1'b1, 1'b0);
    deviceFrame(8'hF4, 1'b0, 11, 1'b1, 4, 0);
    drainScoreboard();
    repeat (5) @(negedge clock50);
    checkOutput("injectSingleDone", doneCount - doneBefore, 32'd1);
    checkOutput("injectIdleBusy", {31'd0, busy}, 32'd0);
    checkOutput("injectIdleClk", {31'd0, ps2Clk}, 32'd1);

    // Reset at edge 6 abandons the frame with no cmd_done.
    doneBefore = doneCount;
    applyStimulus(8'hF4, 1'b0, 1'b0);
    deviceFrame(8'hF4, 1'b0, 11, 1'b1, 0, 6);
    repeat (100) @(negedge clock50);
    checkOutput("resetNoDone", doneCount - doneBefore, 32'd0);
    checkOutput("resetIdleBusy", {31'd0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nErrors);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #(TCLK * 90000);
    nErrors++;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nErrors);
    $finish;
  end

endmodule
